// File: rtl/serial_xor_rx.sv
// ---------------------------------------------------------------------------
// serial_xor_rx
// Receive end of a bit-serial XOR datapath. On each accepted beat it XORs the
// operand bits a_ser/b_ser and builds the results into a WIDTH-bit word. A
// complete word appears on xo together with a one-cycle ready pulse.
//
// Parameters
//   WIDTH      bits per word (>= 1)
//   LSB_FIRST  1: first received bit lands in xo[0]; 0: it lands in xo[WIDTH-1]
//
// Ports
//   clk        clock, all state on the rising edge
//   rstn       asynchronous active-low reset
//   bit_valid  a_ser/b_ser/start/par_ser carry a beat this cycle
//   start      marks the first bit of a word (only looked at with bit_valid)
//   a_ser      serial operand a bit
//   b_ser      serial operand b bit
//   par_ser    even-parity beat that follows the data bits (parity build only)
//   xo         last complete word, bit i = a_i ^ b_i
//   ready      one-cycle pulse: xo holds a new complete word
//   busy       a word is being received
//   err        one-cycle pulse: start seen in the middle of a word
//   perr       parity mismatch, meaningful only while ready is 1
//
// Build option
//   SERIAL_XOR_RX_PARITY_EN  when defined, one extra parity beat follows the
//   data bits and perr reports odd parity over {word, par_ser}. When not
//   defined, par_ser is ignored and perr is always 0.
// ---------------------------------------------------------------------------
module serial_xor_rx #(
    parameter int WIDTH     = 8,
    parameter int LSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             bit_valid,
    input  logic             start,
    input  logic             a_ser,
    input  logic             b_ser,
    input  logic             par_ser,
    output logic [WIDTH-1:0] xo,
    output logic             ready,
    output logic             busy,
    output logic             err,
    output logic             perr
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Writes bit b at logical position pos (order of arrival) into word w,
    // translating the arrival position into an xo index according to LSB_FIRST.
    function automatic logic [WIDTH-1:0] place_bit(input logic [WIDTH-1:0] w,
                                                   input logic [CNT_W-1:0] pos,
                                                   input logic             b);
        logic [WIDTH-1:0] r;
        int               p;
        r = w;
        for (int i = 0; i < WIDTH; i++) begin
            p = (LSB_FIRST != 0) ? i : (WIDTH - 1 - i);
            if (CNT_W'(i) == pos) begin
                r[p] = b;
            end else begin
                r[p] = r[p];
            end
        end
        return r;
    endfunction

    // Even-parity check: 1 when {word, parity bit} has an odd number of ones.
    function automatic logic par_err(input logic [WIDTH-1:0] w, input logic p);
        return ^{w, p};
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] xo_q, xo_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic             perr_q, perr_d;

    logic             bit_s;
    logic [WIDTH-1:0] first_word_s;
    logic [WIDTH-1:0] next_word_s;
    logic [WIDTH-1:0] done_word_s;
    logic             done_s;

    assign bit_s        = a_ser ^ b_ser;
    assign first_word_s = place_bit({WIDTH{1'b0}}, {CNT_W{1'b0}}, bit_s);
    assign next_word_s  = place_bit(sreg_q, cnt_q, bit_s);

`ifndef SERIAL_XOR_RX_PARITY_EN
    logic par_unused_s;
    assign par_unused_s = par_ser;
`endif

    // Next-state and next-output logic of the receive FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sreg_d      = sreg_q;
        xo_d        = xo_q;
        ready_d     = 1'b0;
        busy_d      = busy_q;
        err_d       = 1'b0;
        perr_d      = 1'b0;
        done_s      = 1'b0;
        done_word_s = {WIDTH{1'b0}};

        case (state_q)
            // DONE behaves like IDLE so that a start on the DONE cycle
            // opens the next word with no gap.
            IDLE, DONE: begin
                if (bit_valid && start) begin
                    if (WIDTH == 1) begin
                        done_s      = 1'b1;
                        done_word_s = first_word_s;
                    end else begin
                        sreg_d  = first_word_s;
                        cnt_d   = CNT_W'(1);
                        busy_d  = 1'b1;
                        state_d = SHIFT;
                    end
                end else begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (bit_valid) begin
                    if (start) begin
                        // Framing error: drop the partial word and treat
                        // this beat as bit 0 of a fresh one. xo is untouched.
                        err_d  = 1'b1;
                        sreg_d = first_word_s;
                        cnt_d  = CNT_W'(1);
                    end else if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        done_s      = 1'b1;
                        done_word_s = next_word_s;
                    end else begin
                        sreg_d = next_word_s;
                        cnt_d  = cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d = SHIFT;
                end
            end
            PAR: begin
`ifdef SERIAL_XOR_RX_PARITY_EN
                // start is deliberately ignored on the parity beat.
                if (bit_valid) begin
                    xo_d    = sreg_q;
                    ready_d = 1'b1;
                    perr_d  = par_err(sreg_q, par_ser);
                    busy_d  = 1'b0;
                    state_d = DONE;
                end else begin
                    state_d = PAR;
                end
`else
                busy_d  = 1'b0;
                state_d = IDLE;
`endif
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase

        // Last data bit accepted: publish the word, or park it for parity.
        if (done_s) begin
            cnt_d = {CNT_W{1'b0}};
`ifdef SERIAL_XOR_RX_PARITY_EN
            sreg_d  = done_word_s;
            busy_d  = 1'b1;
            state_d = PAR;
`else
            xo_d    = done_word_s;
            ready_d = 1'b1;
            busy_d  = 1'b0;
            state_d = DONE;
`endif
        end else begin
            cnt_d = cnt_d;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            sreg_q  <= {WIDTH{1'b0}};
            xo_q    <= {WIDTH{1'b0}};
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sreg_q  <= sreg_d;
            xo_q    <= xo_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            perr_q  <= perr_d;
        end
    end

    assign xo    = xo_q;
    assign ready = ready_q;
    assign busy  = busy_q;
    assign err   = err_q;
    assign perr  = perr_q;

endmodule

// File: tb/tb_serial_xor_rx.sv
// Self-checking bench for serial_xor_rx (WIDTH=8, LSB_FIRST=1). Expected words
// come from plain arithmetic (a ^ b, reduction-XOR parity); pulse counts and
// ready spacing are tracked per beat as the stimulus is applied.
module tb_serial_xor_rx;

    localparam int WIDTH = 8;
`ifdef SERIAL_XOR_RX_PARITY_EN
    localparam int PAR_BEATS = 1;
`else
    localparam int PAR_BEATS = 0;
`endif

    logic             clk = 1'b0;
    logic             rstn;
    logic             bit_valid;
    logic             start;
    logic             a_ser;
    logic             b_ser;
    logic             par_ser;
    logic [WIDTH-1:0] xo;
    logic             ready;
    logic             busy;
    logic             err;
    logic             perr;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int ready_seen = 0;
    int err_seen = 0;
    int last_ready_cyc = 0;

    serial_xor_rx #(.WIDTH(WIDTH), .LSB_FIRST(1)) dut (
        .clk(clk), .rstn(rstn), .bit_valid(bit_valid), .start(start),
        .a_ser(a_ser), .b_ser(b_ser), .par_ser(par_ser),
        .xo(xo), .ready(ready), .busy(busy), .err(err), .perr(perr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then move to the next falling edge where the
    // outputs reflect the rising edge that consumed them.
    task automatic step(input logic v, input logic s, input logic a, input logic b, input logic p);
        bit_valid = v; start = s; a_ser = a; b_ser = b; par_ser = p;
        @(negedge clk);
        cyc++;
        if (ready === 1'b1) begin
            ready_seen++;
            last_ready_cyc = cyc;
        end
        if (err === 1'b1) err_seen++;
        if (ready === 1'b1 && err === 1'b1) check("ready_err_exclusive", 32'd1, 32'd0);
    endtask

    task automatic gap(input int maxgap);
        repeat ($urandom_range(maxgap, 0)) step(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    endtask

    // Send one full word (LSB first), optional random gaps, then the parity
    // beat when the parity build is selected.
    task automatic send_word(input logic [7:0] a, input logic [7:0] b, input int maxgap, input logic p);
        for (int k = 0; k < WIDTH; k++) begin
            step(1'b1, (k == 0), a[k], b[k], 1'($urandom));
            if (k == 0) check("busy_after_first", {31'd0, busy}, 32'd1);
            if (k < WIDTH - 1) gap(maxgap);
        end
        if (PAR_BEATS == 1) begin
            gap(maxgap);
            step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), p);
        end
    endtask

    task automatic expect_word(input string tag, input logic [7:0] w, input logic p,
                               input int r0, input int e0, input int exp_errs);
        check({tag, "_ready"}, {31'd0, ready}, 32'd1);
        check({tag, "_xo"}, {24'd0, xo}, {24'd0, w});
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_perr"}, {31'd0, perr}, (PAR_BEATS == 1) ? {31'd0, ^{w, p}} : 32'd0);
        check({tag, "_ready_count"}, ready_seen - r0, 32'd1);
        check({tag, "_err_count"}, err_seen - e0, exp_errs);
    endtask

    initial begin
        int r0, e0, c1;
        logic [7:0] ra, rb;
        logic rp;

        rstn = 1'b0; bit_valid = 1'b0; start = 1'b0;
        a_ser = 1'b0; b_ser = 1'b0; par_ser = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_xo", {24'd0, xo}, 32'd0);
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_perr", {31'd0, perr}, 32'd0);
        rstn = 1'b1;

        // Beat without start in IDLE is ignored.
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("idle_ignore_busy", {31'd0, busy}, 32'd0);
        check("idle_ignore_err", {31'd0, err}, 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Contiguous word: A5 ^ 0F = AA.
        r0 = ready_seen; e0 = err_seen;
        send_word(8'hA5, 8'h0F, 0, 1'b0);
        expect_word("t1", 8'hAA, 1'b0, r0, e0, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t1_ready_one_cycle", {31'd0, ready}, 32'd0);
        check("t1_xo_hold", {24'd0, xo}, 32'h0000_00AA);

        // Same data with random gaps between beats.
        for (int n = 0; n < 3; n++) begin
            r0 = ready_seen; e0 = err_seen;
            send_word(8'hA5, 8'h0F, 3, 1'b0);
            expect_word("t2_gaps", 8'hAA, 1'b0, r0, e0, 0);
            gap(2);
        end

        // XOR truth table in bits 0..3.
        r0 = ready_seen; e0 = err_seen;
        send_word(8'h0C, 8'h0A, 1, 1'b1);
        expect_word("t3_truth", 8'h06, 1'b1, r0, e0, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // start again on beat 4 -> framing error, then the new word completes.
        r0 = ready_seen; e0 = err_seen;
        for (int k = 0; k < 4; k++) step(1'b1, (k == 0), 1'b1, 1'b0, 1'b0);
        check("t4_xo_unchanged", {24'd0, xo}, 32'h0000_0006);
        send_word(8'h3C, 8'h00, 0, 1'b0);
        expect_word("t4_reframe", 8'h3C, 1'b0, r0, e0, 1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Back-to-back words: next start on the DONE cycle.
        r0 = ready_seen; e0 = err_seen;
        send_word(8'h12, 8'h34, 0, 1'b0);
        expect_word("t5_w1", 8'h26, 1'b0, r0, e0, 0);
        c1 = last_ready_cyc;
        r0 = ready_seen;
        send_word(8'hF0, 8'h55, 0, 1'b1);
        expect_word("t5_w2", 8'hA5, 1'b1, r0, e0, 0);
        check("t5_ready_spacing", last_ready_cyc - c1, WIDTH + PAR_BEATS);

        // Reset in the middle of a word.
        for (int k = 0; k < 3; k++) step(1'b1, (k == 0), 1'b1, 1'b0, 1'b0);
        #2 rstn = 1'b0;
        #1;
        check("t5_rst_xo", {24'd0, xo}, 32'd0);
        check("t5_rst_busy", {31'd0, busy}, 32'd0);
        check("t5_rst_ready", {31'd0, ready}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        r0 = ready_seen;
        for (int k = 0; k < WIDTH + 2; k++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("t5_rst_no_ready", ready_seen - r0, 32'd0);
        check("t5_rst_idle_busy", {31'd0, busy}, 32'd0);

        // Parity beat: AA has even weight.
        r0 = ready_seen; e0 = err_seen;
        send_word(8'hAA, 8'h00, 0, 1'b0);
        expect_word("t6_par0", 8'hAA, 1'b0, r0, e0, 0);
        r0 = ready_seen;
        send_word(8'hAA, 8'h00, 1, 1'b1);
        expect_word("t6_par1", 8'hAA, 1'b1, r0, e0, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t6_perr_clear", {31'd0, perr}, 32'd0);

        // Random words, random gaps, sometimes back-to-back.
        for (int n = 0; n < 20; n++) begin
            ra = 8'($urandom); rb = 8'($urandom); rp = 1'($urandom);
            r0 = ready_seen; e0 = err_seen;
            send_word(ra, rb, 2, rp);
            expect_word("rand", ra ^ rb, rp, r0, e0, 0);
            if ($urandom_range(1, 0) == 1) gap(3);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
